// File: rtl/pkt_frame_builder.sv
// Purpose: pops frame commands from a FWFT command FIFO and serializes an Ethernet frame (no FCS) one byte per beat.
// Latency: byte 0 is presented the cycle after the pop; one byte per cycle while the sink is ready.
// Backpressure: tdata/tlast hold while tvalid && !tready; a pop happens only in IDLE, after the inter-frame gap.
module pkt_frame_builder #(
  parameter int IFG_CYCLES   = 12,
  parameter int PAYLOAD_MODE = 0,
  parameter int MIN_LEN      = 60,
  parameter int MAX_LEN      = 1514
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_rd_valid,
  output logic        fifo_rd_enable,
  input  logic [10:0] size,
  input  logic [47:0] d_mac,
  input  logic [47:0] s_mac,
  input  logic [15:0] ethertype,
  input  logic [7:0]  payload,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        busy,
  output logic [31:0] frame_count
);

  localparam int          GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES + 1) : 1;
  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t            state;
  logic [47:0]       d_mac_q;
  logic [47:0]       s_mac_q;
  logic [15:0]       ethertype_q;
  logic [7:0]        payload_q;
  logic [10:0]       len_q;
  logic [10:0]       idx;
  logic [10:0]       idx_nxt;
  logic [10:0]       len_eff;
  logic [GAP_W-1:0]  gap_cnt;

  // Byte k of the frame: DA, SA, ethertype (low byte first), then payload.
  function automatic logic [7:0] frame_byte(
    input logic [10:0] k,
    input logic [47:0] dm,
    input logic [47:0] sm,
    input logic [15:0] et,
    input logic [7:0]  pl
  );
    logic [7:0] b;
    case (k)
      11'd0:   b = dm[7:0];
      11'd1:   b = dm[15:8];
      11'd2:   b = dm[23:16];
      11'd3:   b = dm[31:24];
      11'd4:   b = dm[39:32];
      11'd5:   b = dm[47:40];
      11'd6:   b = sm[7:0];
      11'd7:   b = sm[15:8];
      11'd8:   b = sm[23:16];
      11'd9:   b = sm[31:24];
      11'd10:  b = sm[39:32];
      11'd11:  b = sm[47:40];
      11'd12:  b = et[7:0];
      11'd13:  b = et[15:8];
      default: begin
        // Incrementing payload wraps modulo 256, so only the low index byte matters.
        if (PAYLOAD_MODE != 0) b = pl + (k[7:0] - 8'd14);
        else                   b = pl;
      end
    endcase
    return b;
  endfunction

  // Clamp the requested length into [MIN_LEN, MAX_LEN]; short frames are padded with payload bytes.
  always_comb begin
    len_eff = size;
    if (size < MIN_L)      len_eff = MIN_L;
    else if (size > MAX_L) len_eff = MAX_L;
  end

  // Pop strobe follows FIFO valid while idle; suppressed during reset so nothing is popped and lost.
  always_comb begin
    fifo_rd_enable = (state == IDLE) && fifo_rd_valid && !rst;
    busy           = (state != IDLE);
    idx_nxt        = idx + 11'd1;
  end

  // Frame FSM: latch command on pop, stream bytes on handshakes, then hold off for the inter-frame gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= 8'h00;
      m_axis_tlast  <= 1'b0;
      frame_count   <= 32'd0;
      idx           <= 11'd0;
      len_q         <= 11'd0;
      gap_cnt       <= '0;
      d_mac_q       <= 48'd0;
      s_mac_q       <= 48'd0;
      ethertype_q   <= 16'd0;
      payload_q     <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_rd_enable) begin
            d_mac_q       <= d_mac;
            s_mac_q       <= s_mac;
            ethertype_q   <= ethertype;
            payload_q     <= payload;
            len_q         <= len_eff;
            idx           <= 11'd0;
            m_axis_tdata  <= frame_byte(11'd0, d_mac, s_mac, ethertype, payload);
            m_axis_tlast  <= (len_eff == 11'd1);
            m_axis_tvalid <= 1'b1;
            state         <= SEND;
          end
        end
        SEND: begin
          if (m_axis_tready) begin
            if (m_axis_tlast) begin
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              frame_count   <= frame_count + 32'd1;
              if (IFG_CYCLES > 0) begin
                gap_cnt <= GAP_W'(IFG_CYCLES);
                state   <= GAP;
              end else begin
                state   <= IDLE;
              end
            end else begin
              idx          <= idx_nxt;
              m_axis_tdata <= frame_byte(idx_nxt, d_mac_q, s_mac_q, ethertype_q, payload_q);
              m_axis_tlast <= (idx_nxt == len_q - 11'd1);
            end
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - GAP_W'(1);
          if (gap_cnt == GAP_W'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_frame_builder.sv
module tb_pkt_frame_builder;

  typedef struct packed {
    logic [10:0] size;
    logic [47:0] dm;
    logic [47:0] sm;
    logic [15:0] et;
    logic [7:0]  pl;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tready = 1'b0;
  logic        sel = 1'b0;

  // Command FIFO model (first-word-fall-through), shared by both instances; sel picks the consumer.
  cmd_t        cmds [0:31];
  int          wptr = 0;
  int          rptr = 0;
  int          cyc = 0;
  int          n_pops = 0;
  int          pop_cyc [$];
  cmd_t        head;
  logic        vld0, vld1;

  logic        en0, tv0, tl0, busy0;
  logic [7:0]  td0;
  logic [31:0] fc0;
  logic        en1, tv1, tl1, busy1;
  logic [7:0]  td1;
  logic [31:0] fc1;

  logic        c_tvalid, c_tlast;
  logic [7:0]  c_tdata;

  int          total = 0;
  int          passed = 0;
  int          failed = 0;
  logic [7:0]  got [$];
  bit          gotl [$];
  int          last_cyc;
  int          lc [0:2];
  int          base;

  always #5 clk = ~clk;

  assign head     = cmds[rptr[4:0]];
  assign vld0     = !sel && (rptr != wptr);
  assign vld1     = sel && (rptr != wptr);
  assign c_tvalid = sel ? tv1 : tv0;
  assign c_tdata  = sel ? td1 : td0;
  assign c_tlast  = sel ? tl1 : tl0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sel ? en1 : en0) begin
      rptr <= rptr + 1;
      pop_cyc.push_back(cyc);
      n_pops++;
    end
  end

  pkt_frame_builder #(.IFG_CYCLES(12), .PAYLOAD_MODE(0), .MIN_LEN(60), .MAX_LEN(1514)) dut (
    .clk(clk), .rst(rst), .fifo_rd_valid(vld0), .fifo_rd_enable(en0),
    .size(head.size), .d_mac(head.dm), .s_mac(head.sm), .ethertype(head.et), .payload(head.pl),
    .m_axis_tdata(td0), .m_axis_tvalid(tv0), .m_axis_tready(tready), .m_axis_tlast(tl0),
    .busy(busy0), .frame_count(fc0)
  );

  pkt_frame_builder #(.IFG_CYCLES(0), .PAYLOAD_MODE(1), .MIN_LEN(60), .MAX_LEN(1514)) dut_m1 (
    .clk(clk), .rst(rst), .fifo_rd_valid(vld1), .fifo_rd_enable(en1),
    .size(head.size), .d_mac(head.dm), .s_mac(head.sm), .ethertype(head.et), .payload(head.pl),
    .m_axis_tdata(td1), .m_axis_tvalid(tv1), .m_axis_tready(tready), .m_axis_tlast(tl1),
    .busy(busy1), .frame_count(fc1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [10:0] sz, input logic [47:0] dm, input logic [47:0] sm,
                      input logic [15:0] et, input logic [7:0] pl);
    cmds[wptr[4:0]] = {sz, dm, sm, et, pl};
    wptr++;
  endtask

  // Reference byte for position k of a frame built from command c.
  function automatic logic [7:0] exp_byte(input cmd_t c, input int k, input bit mode);
    logic [47:0] sh;
    if (k < 6) begin
      sh = c.dm >> (8 * k);
      return sh[7:0];
    end else if (k < 12) begin
      sh = c.sm >> (8 * (k - 6));
      return sh[7:0];
    end else if (k == 12) return c.et[7:0];
    else if (k == 13) return c.et[15:8];
    else if (mode) return 8'((int'(c.pl) + k - 14) % 256);
    else return c.pl;
  endfunction

  // Capture handshaken beats until tlast (or stop_after beats); optionally stall randomly and
  // verify outputs hold steady across every stalled cycle.
  task automatic collect(input int budget, input int stop_after, input bit stall);
    bit         done = 0;
    bit         prev_stall = 0;
    logic [7:0] pd = 8'h00;
    logic       pl = 1'b0;
    int         n = 0;
    got.delete();
    gotl.delete();
    while (!done && n < budget) begin
      @(negedge clk);
      if (prev_stall) begin
        chk("stall_tvalid", c_tvalid, 1);
        chk("stall_tdata", c_tdata, pd);
        chk("stall_tlast", c_tlast, pl);
      end
      tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (c_tvalid && tready) begin
        got.push_back(c_tdata);
        gotl.push_back(c_tlast);
        if (c_tlast) begin
          done = 1;
          last_cyc = cyc;
        end
        if (stop_after > 0 && got.size() == stop_after) done = 1;
      end
      prev_stall = c_tvalid && !tready;
      pd = c_tdata;
      pl = c_tlast;
      n++;
    end
    chk("collect_done", done, 1);
  endtask

  task automatic check_frame(input string tag, input cmd_t c, input bit mode, input int explen);
    int nbad = 0;
    int nlast = 0;
    chk({tag, "_len"}, got.size(), explen);
    foreach (got[i]) begin
      if (got[i] !== exp_byte(c, i, mode)) nbad++;
      if (gotl[i]) nlast++;
    end
    chk({tag, "_bytes"}, nbad, 0);
    chk({tag, "_nlast"}, nlast, 1);
    if (got.size() == explen) chk({tag, "_lastpos"}, gotl[explen-1], 1);
  endtask

  initial begin
    cmd_t ca, cb, cc, cd, ce, cf, cg, ch, ci, cj;
    ca = {11'd64,   48'h123456789ABC, 48'h0A0B0C0D0E0F, 16'h0800, 8'h1A};
    cb = {11'd20,   48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h86DD, 8'h5C};
    cc = {11'd2000, 48'h010203040506, 48'h111213141516, 16'h0806, 8'hE7};
    cd = {11'd60,   48'hFFFFFFFFFFFF, 48'h0000000000AA, 16'h88B5, 8'h00};
    ce = {11'd1514, 48'h0C0D0E0F1011, 48'h2122232425FF, 16'h9000, 8'hC3};
    cf = {11'd64,   48'hDEADBEEF0001, 48'hCAFEF00D0002, 16'h1234, 8'h55};
    cg = {11'd64,   48'h0A0A0A0A0A0A, 48'h0B0B0B0B0B0B, 16'h0800, 8'h33};
    ch = {11'd64,   48'h665544332211, 48'h0102030405AB, 16'h0800, 8'h77};
    ci = {11'd64,   48'h123456789ABC, 48'h0A0B0C0D0E0F, 16'h0800, 8'hFE};
    cj = {11'd60,   48'h00000000000F, 48'h00000000000E, 16'h0800, 8'h00};

    // Reset with a command already waiting: nothing may be popped while rst is high.
    push(ca.size, ca.dm, ca.sm, ca.et, ca.pl);
    repeat (3) @(negedge clk);
    chk("rst_en", en0, 0);
    chk("rst_tvalid", tv0, 0);
    chk("rst_tdata", td0, 8'h00);
    chk("rst_tlast", tl0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_fc", fc0, 0);
    rst = 1'b0;
    #1;
    chk("pop_comb", en0, 1);
    @(negedge clk);
    chk("pop_lat_tvalid", tv0, 1);
    chk("pop_lat_tdata", td0, 8'hBC);
    chk("pop_lat_busy", busy0, 1);

    // Frame A: size 64, constant payload 0x1A.
    collect(3000, 0, 0);
    check_frame("A", ca, 0, 64);
    chk("A_b0", got[0], 8'hBC);
    chk("A_b1", got[1], 8'h9A);
    chk("A_b2", got[2], 8'h78);
    chk("A_b3", got[3], 8'h56);
    chk("A_b4", got[4], 8'h34);
    chk("A_b5", got[5], 8'h12);
    chk("A_b6", got[6], 8'h0F);
    chk("A_b12", got[12], 8'h00);
    chk("A_b13", got[13], 8'h08);
    chk("A_b14", got[14], 8'h1A);
    chk("A_b63", got[63], 8'h1A);
    chk("A_last62", gotl[62], 0);
    @(negedge clk);
    chk("A_fc", fc0, 1);
    chk("A_gap_busy", busy0, 1);
    chk("A_gap_tvalid", tv0, 0);

    // Length clamping and boundary lengths.
    push(cb.size, cb.dm, cb.sm, cb.et, cb.pl);
    collect(3000, 0, 0);
    check_frame("B_pad", cb, 0, 60);
    chk("B_b59", got[59], 8'h5C);
    push(cc.size, cc.dm, cc.sm, cc.et, cc.pl);
    collect(3000, 0, 0);
    check_frame("C_trunc", cc, 0, 1514);
    push(cd.size, cd.dm, cd.sm, cd.et, cd.pl);
    collect(3000, 0, 0);
    check_frame("D_min", cd, 0, 60);
    push(ce.size, ce.dm, ce.sm, ce.et, ce.pl);
    collect(3000, 0, 0);
    check_frame("E_max", ce, 0, 1514);
    @(negedge clk);
    chk("E_fc", fc0, 5);

    // Random backpressure: same bytes, outputs held while stalled.
    push(cf.size, cf.dm, cf.sm, cf.et, cf.pl);
    collect(3000, 0, 1);
    check_frame("F_stall", cf, 0, 64);
    @(negedge clk);
    chk("F_fc", fc0, 6);

    // Three queued commands back to back with a 12-cycle gap.
    base = n_pops;
    push(ca.size, ca.dm, ca.sm, ca.et, ca.pl);
    push(cd.size, cd.dm, cd.sm, cd.et, cd.pl);
    push(cb.size, cb.dm, cb.sm, cb.et, cb.pl);
    collect(3000, 0, 0);
    check_frame("G1", ca, 0, 64);
    lc[0] = last_cyc;
    collect(3000, 0, 0);
    check_frame("G2", cd, 0, 60);
    lc[1] = last_cyc;
    collect(3000, 0, 0);
    check_frame("G3", cb, 0, 60);
    lc[2] = last_cyc;
    repeat (20) @(negedge clk);
    chk("b2b_pops", n_pops - base, 3);
    chk("b2b_gap1", pop_cyc[base+1] - lc[0], 13);
    chk("b2b_gap2", pop_cyc[base+2] - lc[1], 13);
    chk("b2b_fc", fc0, 9);
    chk("b2b_idle_busy", busy0, 0);

    // Reset in the middle of a frame, with a new command waiting.
    push(cg.size, cg.dm, cg.sm, cg.et, cg.pl);
    collect(3000, 30, 0);
    @(negedge clk);
    chk("R_beat30", td0, 8'h33);
    rst = 1'b1;
    push(ch.size, ch.dm, ch.sm, ch.et, ch.pl);
    @(negedge clk);
    chk("R_tvalid", tv0, 0);
    chk("R_busy", busy0, 0);
    chk("R_fc", fc0, 0);
    chk("R_en", en0, 0);
    rst = 1'b0;
    collect(3000, 0, 0);
    check_frame("R_new", ch, 0, 64);
    chk("R_new_b0", got[0], 8'h11);
    @(negedge clk);
    chk("R_fc_after", fc0, 1);

    // Incrementing payload, zero inter-frame gap (second instance).
    sel = 1'b1;
    push(ci.size, ci.dm, ci.sm, ci.et, ci.pl);
    push(cj.size, cj.dm, cj.sm, cj.et, cj.pl);
    base = n_pops;
    collect(3000, 0, 0);
    check_frame("M1", ci, 1, 64);
    chk("M1_b14", got[14], 8'hFE);
    chk("M1_b15", got[15], 8'hFF);
    chk("M1_b16", got[16], 8'h00);
    chk("M1_b63", got[63], 8'h2F);
    lc[0] = last_cyc;
    collect(3000, 0, 0);
    check_frame("M2", cj, 1, 60);
    chk("M2_b59", got[59], 8'h2D);
    chk("M_gap0", pop_cyc[base+1] - lc[0], 1);
    @(negedge clk);
    chk("M_fc", fc1, 2);
    chk("M_dut0_quiet", fc0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
